// File: rtl/motor_pkg.sv
// Shared widths and per-side guard state encoding for the motor ramp guard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package motor_pkg;

  localparam int VEL_W  = 7;
  localparam int EDGE_W = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BRAKE = 2'd1,
    FAULT = 2'd2
  } guard_st_t;

endpackage

// File: rtl/ramp_channel.sv
// One wheel: slew-limits v toward tgt, brakes fast, and latches a stall fault.
// Latency: v/fault update one cycle after the deciding tick/brk/stall condition.
// Backpressure: none; the buffer stage samples v every cycle.
module ramp_channel
  import motor_pkg::*;
#(
  parameter int STEP        = 4,
  parameter int BRK_STEP    = 127,
  parameter int STALL_MIN   = 16,
  parameter int STALL_TICKS = 4000
) (
  input  logic              clk_8_bufg,
  input  logic              n_rst,
  input  logic              tick_i,
  input  logic              brk_i,
  input  logic              clr_fault_i,
  input  logic [VEL_W-1:0]  tgt_i,
  input  logic [EDGE_W-1:0] edge_i,
  output logic [VEL_W-1:0]  v_o,
  output logic              fault_o,
  output logic              busy_o
);

  localparam int                CNT_W   = $clog2(STALL_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STALL_TICKS);
  localparam logic [VEL_W-1:0]  STEP_V  = VEL_W'(STEP);
  localparam logic [VEL_W-1:0]  BRK_V   = VEL_W'(BRK_STEP);
  localparam logic [VEL_W-1:0]  MIN_V   = VEL_W'(STALL_MIN);

  guard_st_t         st_q, st_d;
  logic [VEL_W-1:0]  v_q, v_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] s1_q, s2_q, s3_q;

  logic              changed;
  logic [VEL_W-1:0]  up_gap, dn_gap, brake_val;

  // Two-flop synchroniser plus a history stage; a torn sample only ever looks like motion.
  always_ff @(posedge clk_8_bufg) begin
    if (!n_rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= edge_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign changed   = (s2_q != s3_q);
  assign up_gap    = tgt_i - v_q;
  assign dn_gap    = v_q - tgt_i;
  assign brake_val = (v_q > BRK_V) ? (v_q - BRK_V) : '0;

  // Guard FSM and ramp datapath; stall beats brake, brake beats ramp.
  always_comb begin
    st_d  = st_q;
    v_d   = v_q;
    cnt_d = '0;
    unique case (st_q)
      RUN: begin
        if (cnt_q == CNT_MAX) begin
          st_d = FAULT;
          v_d  = '0;
        end else begin
          if ((v_q >= MIN_V) && !changed) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (brk_i) begin
            st_d = BRAKE;
            v_d  = brake_val;
          end else if (tick_i) begin
            if (v_q < tgt_i) begin
              v_d = (up_gap > STEP_V) ? (v_q + STEP_V) : tgt_i;
            end else if (v_q > tgt_i) begin
              v_d = (dn_gap > STEP_V) ? (v_q - STEP_V) : tgt_i;
            end
          end
        end
      end
      BRAKE: begin
        if (brk_i) begin
          v_d = brake_val;
        end else begin
          st_d = RUN;
        end
      end
      FAULT: begin
        v_d = '0;
        if (clr_fault_i && (tgt_i == '0)) begin
          st_d = RUN;
        end
      end
      default: begin
        st_d = RUN;
        v_d  = '0;
      end
    endcase
    fault_d = (st_d == FAULT);
  end

  // State, command, fault flag and stall counter registers.
  always_ff @(posedge clk_8_bufg) begin
    if (!n_rst) begin
      st_q    <= RUN;
      v_q     <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      v_q     <= v_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign v_o     = v_q;
  assign fault_o = fault_q;
  assign busy_o  = (v_q != tgt_i) || (st_q != RUN);

endmodule

// File: rtl/motor_ramp_guard.sv
// Slew limiter and stall guard for both wheels, sharing one ramp prescaler.
// Latency: v_*/fault_* registered (1 cycle); busy is combinational from registered state.
// Backpressure: none; outputs are level commands consumed every cycle.
module motor_ramp_guard
  import motor_pkg::*;
#(
  parameter int STEP        = 4,
  parameter int STEP_DIV    = 8,
  parameter int BRK_STEP    = 127,
  parameter int STALL_MIN   = 16,
  parameter int STALL_TICKS = 4000
) (
  input  logic              clk_8_bufg,
  input  logic              n_rst,
  input  logic              brk,
  input  logic [VEL_W-1:0]  tgt_r,
  input  logic [VEL_W-1:0]  tgt_l,
  input  logic [EDGE_W-1:0] edge_r,
  input  logic [EDGE_W-1:0] edge_l,
  input  logic              clr_fault,
  output logic [VEL_W-1:0]  v_r,
  output logic [VEL_W-1:0]  v_l,
  output logic              fault_r,
  output logic              fault_l,
  output logic              busy
);

  localparam int            PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic             busy_r, busy_l;

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : (pre_q + 1'b1);

  // Shared ramp prescaler: one tick every STEP_DIV cycles.
  always_ff @(posedge clk_8_bufg) begin
    if (!n_rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  ramp_channel #(
    .STEP(STEP), .BRK_STEP(BRK_STEP), .STALL_MIN(STALL_MIN), .STALL_TICKS(STALL_TICKS)
  ) u_right (
    .clk_8_bufg (clk_8_bufg),
    .n_rst      (n_rst),
    .tick_i     (tick),
    .brk_i      (brk),
    .clr_fault_i(clr_fault),
    .tgt_i      (tgt_r),
    .edge_i     (edge_r),
    .v_o        (v_r),
    .fault_o    (fault_r),
    .busy_o     (busy_r)
  );

  ramp_channel #(
    .STEP(STEP), .BRK_STEP(BRK_STEP), .STALL_MIN(STALL_MIN), .STALL_TICKS(STALL_TICKS)
  ) u_left (
    .clk_8_bufg (clk_8_bufg),
    .n_rst      (n_rst),
    .tick_i     (tick),
    .brk_i      (brk),
    .clr_fault_i(clr_fault),
    .tgt_i      (tgt_l),
    .edge_i     (edge_l),
    .v_o        (v_l),
    .fault_o    (fault_l),
    .busy_o     (busy_l)
  );

  assign busy = busy_r | busy_l;

endmodule

// File: tb/tb_motor_ramp_guard.sv
// Directed bench for motor_ramp_guard: ramp, clamp, brake, stall, reset.
// Two instances share stimulus; the second uses a partial brake step of 30.
// Outputs are sampled 1 time unit after each rising edge.
module tb_motor_ramp_guard;

  logic        clk_8_bufg = 1'b0;
  logic        n_rst;
  logic        brk;
  logic [6:0]  tgt_r, tgt_l;
  logic [15:0] edge_r, edge_l;
  logic        clr_fault;
  logic [6:0]  v_r, v_l, v_r_b, v_l_b;
  logic        fault_r, fault_l, busy, fault_r_b, fault_l_b, busy_b;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int per_l = 0;

  always #5 clk_8_bufg = ~clk_8_bufg;

  motor_ramp_guard dut (
    .clk_8_bufg(clk_8_bufg), .n_rst(n_rst), .brk(brk), .tgt_r(tgt_r), .tgt_l(tgt_l),
    .edge_r(edge_r), .edge_l(edge_l), .clr_fault(clr_fault), .v_r(v_r), .v_l(v_l),
    .fault_r(fault_r), .fault_l(fault_l), .busy(busy)
  );

  motor_ramp_guard #(.BRK_STEP(30)) dut_b (
    .clk_8_bufg(clk_8_bufg), .n_rst(n_rst), .brk(brk), .tgt_r(tgt_r), .tgt_l(tgt_l),
    .edge_r(edge_r), .edge_l(edge_l), .clr_fault(clr_fault), .v_r(v_r_b), .v_l(v_l_b),
    .fault_r(fault_r_b), .fault_l(fault_l_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: right encoder always moves, left moves every per_l cycles (0 = frozen).
  task automatic cyc();
    @(posedge clk_8_bufg);
    #1;
    ncyc++;
    edge_r = edge_r + 16'd1;
    if (per_l != 0 && (ncyc % per_l) == 0) edge_l = edge_l + 16'd1;
  endtask

  // Walk v_r to a new target, checking every tick's value against the slew rule.
  task automatic ramp_r(input int target);
    int cur, nxt, n;
    tgt_r = 7'(target);
    cur = int'(v_r);
    while (cur != target) begin
      if (cur < target) nxt = (cur + 4 < target) ? cur + 4 : target;
      else              nxt = (cur - 4 > target) ? cur - 4 : target;
      n = 0;
      while (int'(v_r) == cur && n < 10) begin
        cyc();
        n++;
      end
      chk("ramp_r_step", 32'(v_r), nxt);
      if (int'(v_r) != nxt) break;
      cur = nxt;
    end
  endtask

  // Wait (bounded) for v_l to change; report the new value.
  task automatic wait_vl(output int val);
    int n;
    int prev;
    prev = int'(v_l);
    n = 0;
    while (int'(v_l) == prev && n < 10) begin
      cyc();
      n++;
    end
    val = int'(v_l);
  endtask

  initial begin
    int c16, cf, val, seen;
    n_rst = 1'b0; brk = 1'b0; clr_fault = 1'b0;
    tgt_r = '0; tgt_l = '0; edge_r = '0; edge_l = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_v_r", 32'(v_r), 0);
    chk("rst_v_l", 32'(v_l), 0);
    chk("rst_fault_r", 32'(fault_r), 0);
    chk("rst_fault_l", 32'(fault_l), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_v_r_b", 32'(v_r_b), 0);

    // Ramp up 0 -> 100: first tick on the 8th edge after release, +4 per tick
    tgt_r = 7'd100;
    n_rst = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      repeat (7) cyc();
      chk("up_pre", 32'(v_r), 4 * (k - 1));
      if (k == 25) chk("up_busy_before", 32'(busy), 1);
      cyc();
      chk("up_post", 32'(v_r), (k == 25) ? 100 : 4 * k);
    end
    chk("up_busy_after", 32'(busy), 0);
    repeat (16) cyc();
    chk("up_hold", 32'(v_r), 100);

    // Ramp down with no undershoot, then up to full scale with no wrap
    ramp_r(2);
    repeat (16) cyc();
    chk("down_hold", 32'(v_r), 2);
    ramp_r(125);
    ramp_r(127);
    repeat (16) cyc();
    chk("top_hold", 32'(v_r), 127);
    ramp_r(80);

    // Brake: full step zeroes at once; step 30 goes 50, 20, 0
    chk("brk_start_b", 32'(v_r_b), 80);
    brk = 1'b1;
    cyc();
    chk("brk_full", 32'(v_r), 0);
    chk("brk_b1", 32'(v_r_b), 50);
    chk("brk_busy", 32'(busy), 1);
    cyc();
    chk("brk_b2", 32'(v_r_b), 20);
    cyc();
    chk("brk_b3", 32'(v_r_b), 0);
    brk = 1'b0;
    cyc();
    chk("brk_rel_hold", 32'(v_r), 0);
    ramp_r(80);
    chk("brk_resume_b", 32'(v_r_b), 80);

    // Stall: left target 64 with frozen encoder
    per_l = 0;
    tgt_l = 7'd64;
    c16 = -1; cf = -1;
    for (int i = 0; i < 6000; i++) begin
      cyc();
      if (c16 < 0 && v_l >= 7'd16) c16 = i;
      if (fault_l) begin
        cf = i;
        break;
      end
    end
    chk("stall_fault", 32'(fault_l), 1);
    chk("stall_v_zero", 32'(v_l), 0);
    chk("stall_latency", cf - c16, 4001);
    chk("stall_right_fault", 32'(fault_r), 0);
    chk("stall_right_v", 32'(v_r), 80);

    clr_fault = 1'b1;
    cyc();
    chk("clr_ignored", 32'(fault_l), 1);
    chk("clr_ignored_v", 32'(v_l), 0);
    clr_fault = 1'b0;
    brk = 1'b1;
    tgt_r = 7'd0;
    cyc();
    chk("fault_brk_fault", 32'(fault_l), 1);
    chk("fault_brk_v", 32'(v_l), 0);
    brk = 1'b0;
    cyc();
    tgt_l = 7'd0;
    clr_fault = 1'b1;
    cyc();
    chk("clr_ok", 32'(fault_l), 0);
    chk("clr_busy", 32'(busy), 0);
    clr_fault = 1'b0;

    // No false stall: encoder moves every 1000 cycles
    per_l = 1000;
    tgt_l = 7'd64;
    seen = 0;
    repeat (10000) begin
      cyc();
      if (fault_l) seen = 1;
    end
    chk("slow_edges_no_fault", seen, 0);
    chk("slow_edges_v", 32'(v_l), 64);

    // Below monitor threshold with frozen encoder
    per_l = 0;
    tgt_l = 7'd10;
    seen = 0;
    repeat (5000) begin
      cyc();
      if (fault_l) seen = 1;
    end
    chk("low_v_no_fault", seen, 0);
    chk("low_v_val", 32'(v_l), 10);

    // Reset mid-ramp: immediate zero, no ramp-down
    tgt_r = 7'd120;
    repeat (40) cyc();
    chk("mid_ramp_moving", 32'(v_r > 7'd0), 1);
    n_rst = 1'b0;
    tgt_r = 7'd0;
    tgt_l = 7'd0;
    cyc();
    chk("rst_mid_v_r", 32'(v_r), 0);
    chk("rst_mid_v_l", 32'(v_l), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    n_rst = 1'b1;

    // Reset during FAULT
    tgt_l = 7'd64;
    for (int i = 0; i < 6000; i++) begin
      cyc();
      if (fault_l) break;
    end
    chk("fault2_set", 32'(fault_l), 1);
    n_rst = 1'b0;
    tgt_l = 7'd0;
    cyc();
    chk("rst_fault_clr", 32'(fault_l), 0);
    chk("rst_fault_v", 32'(v_l), 0);
    chk("rst_fault_busy", 32'(busy), 0);
    n_rst = 1'b1;
    tgt_l = 7'd20;
    wait_vl(val);
    chk("rst_fault_run", val, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
